w_writeback: RTL and testbench
==============================

// Module: w_writeback
// PURPOSE
//  W-stage pipeline register plus write-back path: the producer end of the GRF write port.
//  Latches M-stage results on each enabled clock edge.
//  Extracts and extends load data, then selects the write-back value.
//  Drives W_RFWr/W_A3/W_WD/W_PC into the GRF and the forwarding network.
//  Also keeps a retired-instruction counter for trace and debug.
// PARAMETERS
//  RESET_PC   32'h0000_3000  W_PC value held while in reset / after flush
//  CNT_W      32             width of retired-instruction counter
// PORTS
//  clk        in   1      system clock, all state updates on posedge
//  reset      in   1      synchronous, ACTIVE-LOW (reset==0 clears state at posedge clk)
//  en         in   1      1: load M-stage inputs; 0: hold all W state (stall)
//  flush      in   1      1 with en: load a bubble instead of M inputs
//  M_PC       in   32     PC of instruction in M
//  M_RFWr     in   1      M instruction writes GRF
//  M_A3       in   5      destination register
//  M_ALUOut   in   32     ALU result; also the effective address for loads
//  M_DMRd     in   32     raw aligned word read from DM
//  M_WDSel    in   2      `WD_ALU / `WD_DM / `WD_PC8
//  M_LdType   in   3      `LD_W / `LD_H / `LD_HU / `LD_B / `LD_BU
//  W_RFWr     out  1      GRF write enable
//  W_A3       out  5      GRF write address
//  W_WD       out  32     GRF write data
//  W_PC       out  32     PC of the instruction being written back
//  W_retired  out  CNT_W  count of non-bubble instructions that reached W
// BEHAVIOUR
//  - Reset (reset==0 at posedge): RFWr=0, A3=0, all data regs=0, PC=RESET_PC, W_retired=0.
//    Reset wins over en and flush.
//  - en==1, flush==0: register M_* inputs. Latency is one cycle, M to W.
//  - en==1, flush==1: load a bubble, with the same values as reset except W_retired,
//    which is held.
//  - en==0: every register holds, flush is ignored, and W outputs stay stable.
//  - W_A3 is forced to 0 whenever the registered RFWr==0.
//  - W_RFWr is forced to 0 when the registered A3==0. GRF therefore never sees a $0 write.
//  - W_WD is combinational from the registered fields:
//      `WD_ALU -> ALUOut; `WD_PC8 -> PC+8 (32-bit wrap);
//      `WD_DM  -> load extraction using ALUOut[1:0]:
//        LD_W: whole word
//        LD_H/HU: halfword ALUOut[1] (0 = bits[15:0], 1 = bits[31:16]), sign/zero extended
//        LD_B/BU: byte ALUOut[1:0] (0 = bits[7:0] ... 3 = bits[31:24]), sign/zero extended
//      Unlisted WDSel or LdType encodings -> W_WD=0 and W_RFWr=0.
//  - Misalignment (LD_W with ALUOut[1:0]!=0, or H/HU with ALUOut[0]!=0) is not trapped here.
//    The value is extracted from the aligned word as specified above.
//  - W_retired counts a cycle when all of the following hold: en==1, flush==0,
//    reset==1, and the latched M_PC != 0. Wraps at 2^CNT_W.
//  - Simultaneous flush and en==0: hold takes priority, so no bubble is inserted.
// STRUCTURE
//  - def.v (shared): `WD_ALU=2'd0, `WD_DM=2'd1, `WD_PC8=2'd2; `LD_W=3'd0, `LD_H=3'd1,
//    `LD_HU=3'd2, `LD_B=3'd3, `LD_BU=3'd4.
//  - One sub-module, w_load_ext: purely combinational (word, addr[1:0], ldtype) -> data.
//  - The pipeline register and the WD mux stay in w_writeback.
// TESTING
//  1 reset=0 for 2 cycles, then reset=1 -> W_RFWr=0, W_A3=0, W_PC=32'h3000, W_retired=0.
//  2 Load with en=1: M_RFWr=1, A3=5, WD_ALU, ALUOut=32'h1234_5678, PC=32'h3004.
//    -> next cycle W_RFWr=1, W_A3=5, W_WD=32'h1234_5678, W_PC=32'h3004, W_retired=1.
//  3 DMRd=32'h80FF_7F01, WD_DM, with each of:
//      LD_B  at addr 2'b11 -> W_WD=32'hFFFF_FF80
//      LD_BU at addr 2'b11 -> W_WD=32'h0000_0080
//      LD_H  at addr 2'b00 -> W_WD=32'h0000_7F01
//      LD_H  at addr 2'b10 -> W_WD=32'hFFFF_80FF
//  4 WD_PC8, PC=32'h3010, A3=31 -> W_WD=32'h3018.
//    Same instruction with A3=0 -> W_RFWr=0.
//  5 en=0 for 3 cycles while M inputs change -> W outputs and W_retired unchanged.
//    Then flush=1, en=1 -> bubble: W_RFWr=0, W_PC=32'h3000, W_retired unchanged.
//  6 reset=0 asserted mid-stream with en=1, flush=1 -> full reset values next cycle,
//    W_retired=0. Also run W_retired from 32'hFFFF_FFFF plus one retire -> wraps to 0.

Source files
------------

// File: rtl/w_writeback_pkg.sv
// w_writeback_pkg: write-back select/load encodings and the W-stage register bundle.
package w_writeback_pkg;
  localparam logic [1:0] WD_ALU = 2'd0, WD_DM = 2'd1, WD_PC8 = 2'd2;
  localparam logic [2:0] LD_W = 3'd0, LD_H = 3'd1, LD_HU = 3'd2, LD_B = 3'd3, LD_BU = 3'd4;
  typedef struct packed {
    logic        rfwr;
    logic [4:0]  a3;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] dmrd;
    logic [1:0]  wdsel;
    logic [2:0]  ldtype;
  } w_regs_t;
endpackage

// File: rtl/w_load_ext.sv
// w_load_ext: extracts and sign/zero extends load data from an aligned DM word.
module w_load_ext
  import w_writeback_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  ldtype_i,
  output logic [31:0] data_o,
  output logic        ok_o
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word_i[{addr_i, 3'b000} +: 8];
    h = addr_i[1] ? word_i[31:16] : word_i[15:0];
    ok_o = ldtype_i <= LD_BU;
    data_o = ldtype_i == LD_W  ? word_i :
             ldtype_i == LD_H  ? {{16{h[15]}}, h} :
             ldtype_i == LD_HU ? {16'b0, h} :
             ldtype_i == LD_B  ? {{24{b[7]}}, b} :
             ldtype_i == LD_BU ? {24'b0, b} : 32'b0;
  end
endmodule

// File: rtl/w_writeback.sv
// w_writeback: W-stage pipeline register, write-back mux and retired-instruction counter.
module w_writeback
  import w_writeback_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [31:0]      M_PC,
  input  logic             M_RFWr,
  input  logic [4:0]       M_A3,
  input  logic [31:0]      M_ALUOut,
  input  logic [31:0]      M_DMRd,
  input  logic [1:0]       M_WDSel,
  input  logic [2:0]       M_LdType,
  output logic             W_RFWr,
  output logic [4:0]       W_A3,
  output logic [31:0]      W_WD,
  output logic [31:0]      W_PC,
  output logic [CNT_W-1:0] W_retired
);
  localparam w_regs_t BUBBLE = '{rfwr: 1'b0, a3: 5'd0, pc: RESET_PC, alu: 32'd0,
                                 dmrd: 32'd0, wdsel: 2'd0, ldtype: 3'd0};
  w_regs_t          w_q, w_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [31:0]      ld_data;
  logic             ld_ok, wd_ok;
  always_comb begin
    w_d = !en ? w_q : flush ? BUBBLE :
          w_regs_t'{rfwr: M_RFWr, a3: M_A3, pc: M_PC, alu: M_ALUOut,
                    dmrd: M_DMRd, wdsel: M_WDSel, ldtype: M_LdType};
    ret_d = ret_q + CNT_W'(en && !flush && M_PC != 32'd0);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      w_q   <= BUBBLE;
      ret_q <= '0;
    end else begin
      w_q   <= w_d;
      ret_q <= ret_d;
    end
  end
  w_load_ext u_ld (
    .word_i  (w_q.dmrd),
    .addr_i  (w_q.alu[1:0]),
    .ldtype_i(w_q.ldtype),
    .data_o  (ld_data),
    .ok_o    (ld_ok)
  );
  // Illegal select or load encodings suppress both the data and the write.
  always_comb begin
    wd_ok = w_q.wdsel == WD_ALU || w_q.wdsel == WD_PC8 || (w_q.wdsel == WD_DM && ld_ok);
    W_WD = !wd_ok ? 32'd0 : w_q.wdsel == WD_ALU ? w_q.alu :
           w_q.wdsel == WD_PC8 ? w_q.pc + 32'd8 : ld_data;
    W_RFWr = w_q.rfwr && w_q.a3 != 5'd0 && wd_ok;
    W_A3 = w_q.rfwr ? w_q.a3 : 5'd0;
    W_PC = w_q.pc;
    W_retired = ret_q;
  end
endmodule

// File: tb/tb_w_writeback.sv
// tb_w_writeback: directed vectors, expected results queued by the driver and checked by a monitor.
module tb_w_writeback;
  import w_writeback_pkg::*;
  typedef struct {
    logic        rfwr;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [31:0] ret;
  } exp_t;
  logic clk = 0, reset, en, flush, M_RFWr;
  logic [31:0] M_PC, M_ALUOut, M_DMRd;
  logic [4:0] M_A3;
  logic [1:0] M_WDSel;
  logic [2:0] M_LdType;
  logic W_RFWr, s_RFWr;
  logic [4:0] W_A3, s_A3;
  logic [31:0] W_WD, W_PC, W_retired, s_WD, s_PC;
  logic [2:0] s_retired;
  exp_t q[$];
  int checks = 0, errors = 0, vec = 0;
  always #5 clk = ~clk;
  w_writeback dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .M_PC(M_PC), .M_RFWr(M_RFWr),
    .M_A3(M_A3), .M_ALUOut(M_ALUOut), .M_DMRd(M_DMRd), .M_WDSel(M_WDSel),
    .M_LdType(M_LdType), .W_RFWr(W_RFWr), .W_A3(W_A3), .W_WD(W_WD), .W_PC(W_PC),
    .W_retired(W_retired)
  );
  // Narrow counter copy sharing the same stimulus, so counter wrap is reachable quickly.
  w_writeback #(.CNT_W(3)) dut_small (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .M_PC(M_PC), .M_RFWr(M_RFWr),
    .M_A3(M_A3), .M_ALUOut(M_ALUOut), .M_DMRd(M_DMRd), .M_WDSel(M_WDSel),
    .M_LdType(M_LdType), .W_RFWr(s_RFWr), .W_A3(s_A3), .W_WD(s_WD), .W_PC(s_PC),
    .W_retired(s_retired)
  );
  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask
  task automatic drive(input logic rst, input logic en_v, input logic fl, input logic [31:0] pc,
                       input logic rf, input logic [4:0] a3, input logic [31:0] alu,
                       input logic [31:0] dm, input logic [1:0] ws, input logic [2:0] lt,
                       input logic erf, input logic [4:0] ea3, input logic [31:0] ewd,
                       input logic [31:0] epc, input logic [31:0] eret);
    reset = rst; en = en_v; flush = fl; M_PC = pc; M_RFWr = rf; M_A3 = a3;
    M_ALUOut = alu; M_DMRd = dm; M_WDSel = ws; M_LdType = lt;
    q.push_back('{erf, ea3, ewd, epc, eret});
    @(posedge clk);
    #2;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vec++;
        chk("W_RFWr", vec, 32'(W_RFWr), 32'(e.rfwr));
        chk("W_A3", vec, 32'(W_A3), 32'(e.a3));
        chk("W_WD", vec, W_WD, e.wd);
        chk("W_PC", vec, W_PC, e.pc);
        chk("W_retired", vec, W_retired, e.ret);
        chk("retired_wrap3", vec, 32'(s_retired), e.ret & 32'd7);
      end
    end
  end
  localparam logic [31:0] DM = 32'h80FF_7F01;
  initial begin
    int n;
    // rst en fl  pc  rf a3 alu dm ws lt | expected rfwr a3 wd pc retired
    drive(0, 1, 0, 32'h3004, 1, 5, 32'h1234_5678, DM, WD_ALU, LD_W, 0, 0, 0, 32'h3000, 0);
    drive(0, 1, 0, 32'h3004, 1, 5, 32'h1234_5678, DM, WD_ALU, LD_W, 0, 0, 0, 32'h3000, 0);
    drive(1, 1, 0, 32'h3004, 1, 5, 32'h1234_5678, DM, WD_ALU, LD_W, 1, 5, 32'h1234_5678, 32'h3004, 1);
    drive(1, 1, 0, 32'h3008, 1, 6, 32'h1003, DM, WD_DM, LD_B, 1, 6, 32'hFFFF_FF80, 32'h3008, 2);
    drive(1, 1, 0, 32'h300C, 1, 7, 32'h1003, DM, WD_DM, LD_BU, 1, 7, 32'h0000_0080, 32'h300C, 3);
    drive(1, 1, 0, 32'h3010, 1, 8, 32'h1000, DM, WD_DM, LD_H, 1, 8, 32'h0000_7F01, 32'h3010, 4);
    drive(1, 1, 0, 32'h3014, 1, 9, 32'h1002, DM, WD_DM, LD_H, 1, 9, 32'hFFFF_80FF, 32'h3014, 5);
    drive(1, 1, 0, 32'h3018, 1, 10, 32'h1002, DM, WD_DM, LD_HU, 1, 10, 32'h0000_80FF, 32'h3018, 6);
    drive(1, 1, 0, 32'h301C, 1, 11, 32'h1001, DM, WD_DM, LD_W, 1, 11, DM, 32'h301C, 7);
    drive(1, 1, 0, 32'h3020, 1, 12, 32'h1001, DM, WD_DM, LD_B, 1, 12, 32'h0000_007F, 32'h3020, 8);
    drive(1, 1, 0, 32'h3010, 1, 31, 32'h5, DM, WD_PC8, LD_W, 1, 31, 32'h3018, 32'h3010, 9);
    drive(1, 1, 0, 32'h3010, 1, 0, 32'h5, DM, WD_PC8, LD_W, 0, 0, 32'h3018, 32'h3010, 10);
    drive(1, 1, 0, 32'h3024, 1, 3, 32'h55, DM, 2'd3, LD_W, 0, 3, 0, 32'h3024, 11);
    drive(1, 1, 0, 32'h3028, 1, 4, 32'h55, DM, WD_DM, 3'd5, 0, 4, 0, 32'h3028, 12);
    drive(1, 1, 0, 32'h302C, 0, 9, 32'h77, DM, WD_ALU, LD_W, 0, 0, 32'h77, 32'h302C, 13);
    drive(1, 1, 0, 32'h0, 1, 2, 32'h99, DM, WD_ALU, LD_W, 1, 2, 32'h99, 32'h0, 13);
    drive(1, 1, 0, 32'h3030, 1, 5, 32'hAAAA, DM, WD_ALU, LD_W, 1, 5, 32'hAAAA, 32'h3030, 14);
    drive(1, 0, 0, 32'h4000, 1, 9, 32'h1111, DM, WD_PC8, LD_W, 1, 5, 32'hAAAA, 32'h3030, 14);
    drive(1, 0, 1, 32'h4004, 1, 8, 32'h2222, DM, WD_DM, LD_B, 1, 5, 32'hAAAA, 32'h3030, 14);
    drive(1, 0, 0, 32'h4008, 0, 7, 32'h3333, DM, WD_ALU, LD_H, 1, 5, 32'hAAAA, 32'h3030, 14);
    drive(1, 1, 1, 32'h400C, 1, 6, 32'h4444, DM, WD_ALU, LD_W, 0, 0, 0, 32'h3000, 14);
    drive(1, 1, 0, 32'h3034, 1, 6, 32'hBBBB, DM, WD_ALU, LD_W, 1, 6, 32'hBBBB, 32'h3034, 15);
    drive(0, 1, 1, 32'h3038, 1, 7, 32'hCCCC, DM, WD_ALU, LD_W, 0, 0, 0, 32'h3000, 0);
    drive(1, 1, 0, 32'h3038, 1, 1, 32'h1, DM, WD_ALU, LD_W, 1, 1, 32'h1, 32'h3038, 1);
    en = 0;
    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    #3;
    chk("queue_drained", vec, 32'(q.size()), 0);
    chk("vectors_seen", vec, 32'(vec), 24);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
